// File: rtl/irq_pending_arbiter.sv
// Sticky 8-line interrupt capture with masked highest-index-wins selection into a registered valid/ready output.
// Pending is set one edge after a request, granted the following edge; irq_id holds until irq_ready, back-to-back on accept.
module irq_pending_arbiter #(
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic [7:0] mask,
  input  logic       irq_ready,
  input  logic       clear_missed,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic [7:0] pending,
  output logic [7:0] missed
);

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] missed_q, missed_d;
  logic [2:0] id_q, id_d;

  logic [7:0] hit;
  logic [7:0] cand;
  logic [7:0] held;
  logic [7:0] load_vec;
  logic [7:0] miss_ev;
  logic [2:0] win_idx;
  logic       load;

  // Selection looks only at registered pending, so a request arriving this
  // cycle can never pre-empt the grant being loaded on this edge.
  always_comb begin
    hit     = EDGE_MODE ? (req_in & ~req_q) : req_in;
    cand    = pending_q & ~mask;
    win_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (cand[i]) win_idx = 3'(i);
    end
    held = (state_q == HELD) ? (8'd1 << id_q) : 8'd0;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (|cand) begin
          load    = 1'b1;
          id_d    = win_idx;
          state_d = HELD;
        end
      end
      HELD: begin
        if (irq_ready) begin
          if (|cand) begin
            load = 1'b1;
            id_d = win_idx;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A bit leaving pending for irq_id on the same edge as a new hit is not a
  // collision: the hit simply re-pends it.
  always_comb begin
    load_vec  = load ? (8'd1 << win_idx) : 8'd0;
    miss_ev   = EDGE_MODE ? (hit & ((pending_q & ~load_vec) | held)) : (hit & held);
    pending_d = (pending_q & ~load_vec) | hit;
    missed_d  = (clear_missed ? 8'd0 : missed_q) | miss_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      id_q      <= 3'd0;
      req_q     <= 8'h00;
      pending_q <= 8'h00;
      missed_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      req_q     <= req_in;
      pending_q <= pending_d;
      missed_q  <= missed_d;
    end
  end

  assign irq_valid = (state_q == HELD);
  assign irq_id    = id_q;
  assign pending   = pending_q;
  assign missed    = missed_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Bench for irq_pending_arbiter: edge- and level-mode instances share stimulus and are checked against an abstract model.
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ready;
  logic       clear_missed;

  logic       vld_e, vld_l;
  logic [2:0] id_e, id_l;
  logic [7:0] pend_e, pend_l;
  logic [7:0] miss_e, miss_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  irq_pending_arbiter #(.EDGE_MODE(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
    .irq_ready(irq_ready), .clear_missed(clear_missed),
    .irq_valid(vld_e), .irq_id(id_e), .pending(pend_e), .missed(miss_e)
  );

  irq_pending_arbiter #(.EDGE_MODE(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask),
    .irq_ready(irq_ready), .clear_missed(clear_missed),
    .irq_valid(vld_l), .irq_id(id_l), .pending(pend_l), .missed(miss_l)
  );

  // Reference state per instance: index 0 = level mode, 1 = edge mode.
  bit [7:0] m_req[2];
  bit [7:0] m_pend[2];
  bit [7:0] m_miss[2];
  bit       m_vld[2];
  int       m_id[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int top_index(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_req[m] = 8'h00; m_pend[m] = 8'h00; m_miss[m] = 8'h00;
      m_vld[m] = 1'b0;  m_id[m] = 0;
    end
  endtask

  task automatic model_step(input int m);
    int       w;
    int       g;
    bit       h;
    bit [7:0] np;
    bit [7:0] nm;
    w = top_index(m_pend[m] & ~mask);
    g = -1;
    if (w >= 0 && (!m_vld[m] || irq_ready)) g = w;
    np = m_pend[m];
    nm = clear_missed ? 8'h00 : m_miss[m];
    if (g >= 0) np[g] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      h = (m == 1) ? (req_in[i] && !m_req[m][i]) : req_in[i];
      if (h) begin
        if ((m_vld[m] && m_id[m] == i) || (m == 1 && m_pend[m][i] && i != g)) nm[i] = 1'b1;
        np[i] = 1'b1;
      end
    end
    if (g >= 0) begin
      m_vld[m] = 1'b1;
      m_id[m]  = g;
    end else if (irq_ready) begin
      m_vld[m] = 1'b0;
    end
    m_pend[m] = np;
    m_miss[m] = nm;
    m_req[m]  = req_in;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".vld_e"},  32'(vld_e),  32'(m_vld[1]));
    check({tag, ".pend_e"}, 32'(pend_e), 32'(m_pend[1]));
    check({tag, ".miss_e"}, 32'(miss_e), 32'(m_miss[1]));
    if (m_vld[1]) check({tag, ".id_e"}, 32'(id_e), 32'(m_id[1]));
    check({tag, ".vld_l"},  32'(vld_l),  32'(m_vld[0]));
    check({tag, ".pend_l"}, 32'(pend_l), 32'(m_pend[0]));
    check({tag, ".miss_l"}, 32'(miss_l), 32'(m_miss[0]));
    if (m_vld[0]) check({tag, ".id_l"}, 32'(id_l), 32'(m_id[0]));
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic [7:0] mk,
                       input logic rdy, input logic cm);
    req_in = r; mask = mk; irq_ready = rdy; clear_missed = cm;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all(tag);
  endtask

  int exp_ids[4] = '{7, 5, 2, 0};

  initial begin
    rst_n = 1'b0; req_in = 8'h00; mask = 8'h00; irq_ready = 1'b0; clear_missed = 1'b0;
    model_reset();
    #22;
    check("rst.vld", 32'(vld_e), 32'd0);
    check("rst.id", 32'(id_e), 32'd0);
    check("rst.pend", 32'(pend_e), 32'd0);
    check("rst.miss", 32'(miss_e), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single edge
    cycle("single0", 8'h10, 8'h00, 1'b1, 1'b0);
    check("single.pend", 32'(pend_e), 32'h10);
    cycle("single1", 8'h00, 8'h00, 1'b1, 1'b0);
    check("single.vld", 32'(vld_e), 32'd1);
    check("single.id", 32'(id_e), 32'd4);
    check("single.pend_clr", 32'(pend_e), 32'h00);
    cycle("single2", 8'h00, 8'h00, 1'b1, 1'b0);
    check("single.drop", 32'(vld_e), 32'd0);

    // Priority, back-to-back
    cycle("b2b0", 8'hA5, 8'h00, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle("b2b", 8'h00, 8'h00, 1'b1, 1'b0);
      check("b2b.vld", 32'(vld_e), 32'd1);
      check("b2b.id", 32'(id_e), 32'(exp_ids[k]));
    end
    cycle("b2b_end", 8'h00, 8'h00, 1'b1, 1'b0);

    // Backpressure
    cycle("bp0", 8'h03, 8'h00, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cycle("bp", 8'h00, 8'h00, 1'b0, 1'b0);
      check("bp.id", 32'(id_e), 32'd1);
      check("bp.pend", 32'(pend_e), 32'h01);
    end
    cycle("bp_acc", 8'h00, 8'h00, 1'b1, 1'b0);
    check("bp.next", 32'(id_e), 32'd0);
    cycle("bp_end", 8'h00, 8'h00, 1'b1, 1'b0);

    // Masking
    cycle("mask0", 8'h88, 8'h80, 1'b1, 1'b0);
    cycle("mask1", 8'h00, 8'h80, 1'b1, 1'b0);
    check("mask.id", 32'(id_e), 32'd3);
    cycle("mask2", 8'h00, 8'h80, 1'b1, 1'b0);
    check("mask.pend", 32'(pend_e), 32'h80);
    cycle("mask3", 8'h00, 8'h00, 1'b1, 1'b0);
    check("mask.unmask_id", 32'(id_e), 32'd7);
    cycle("mask4", 8'h00, 8'h00, 1'b1, 1'b0);

    // Missed while held, clear, then collision with load
    cycle("miss0", 8'h04, 8'h00, 1'b0, 1'b0);
    cycle("miss1", 8'h00, 8'h00, 1'b0, 1'b0);
    cycle("miss2", 8'h04, 8'h00, 1'b0, 1'b0);
    check("miss.set", 32'(miss_e), 32'h04);
    cycle("miss3", 8'h00, 8'h00, 1'b0, 1'b1);
    check("miss.clr", 32'(miss_e), 32'h00);
    cycle("miss4", 8'h00, 8'h00, 1'b1, 1'b0);
    cycle("miss5", 8'h00, 8'h00, 1'b1, 1'b0);
    cycle("coll0", 8'h04, 8'h04, 1'b1, 1'b0);
    cycle("coll1", 8'h00, 8'h04, 1'b1, 1'b0);
    cycle("coll2", 8'h04, 8'h00, 1'b1, 1'b0);
    check("coll.id", 32'(id_e), 32'd2);
    check("coll.pend", 32'(pend_e), 32'h04);
    check("coll.miss", 32'(miss_e), 32'h00);
    cycle("coll3", 8'h00, 8'h00, 1'b1, 1'b0);
    cycle("coll4", 8'h00, 8'h00, 1'b1, 1'b0);

    // Reset mid-handshake
    cycle("rmid0", 8'hBC, 8'h00, 1'b0, 1'b0);
    cycle("rmid1", 8'h00, 8'h00, 1'b0, 1'b0);
    check("rmid.pend", 32'(pend_e), 32'h3C);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check("rmid.vld_e", 32'(vld_e), 32'd0);
    check("rmid.vld_l", 32'(vld_l), 32'd0);
    check("rmid.pend_e", 32'(pend_e), 32'd0);
    check("rmid.id_e", 32'(id_e), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle("post_rst", 8'h00, 8'h00, 1'b1, 1'b0);
      check("post_rst.vld", 32'(vld_e), 32'd0);
    end

    // Random traffic
    begin
      logic [7:0] mk;
      mk = 8'h00;
      for (int k = 0; k < 2000; k++) begin
        if ($urandom_range(0, 15) == 0) mk = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
        cycle("rand", 8'($urandom_range(0, 255) & $urandom_range(0, 255)), mk,
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
